// File: rtl/tim_pkg.sv
// Shared constants for the cog/PLL clock-rate scheduler and counter modules.
package tim_pkg;

    localparam logic [4:0] SEL_PLL16X = 5'b11111;
    localparam logic [4:0] SEL_PLL8X  = 5'b11110;
    localparam logic [4:0] SEL_PLL4X  = 5'b11101;
    localparam logic [4:0] SEL_PLL2X  = 5'b11100;
    localparam logic [4:0] SEL_PLL1X  = 5'b11011;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SETTLE = 2'd2
    } tim_state_e;

endpackage

// File: rtl/tim_inc_lut.sv
// Maps a 5-bit clock select to the per-clk accumulator increment; zero stops the clock.
module tim_inc_lut
    import tim_pkg::*;
#(
    parameter int DIV_W = 13
) (
    input  logic [4:0]       sel,
    output logic [DIV_W-1:0] inc
);

    // PLL codes are matched first; none of them alias the RC/XINPUT partial decodes.
    always_comb begin
        inc = '0;
        if (sel == SEL_PLL16X) begin
            inc[DIV_W-1] = 1'b1;
        end else if (sel == SEL_PLL8X) begin
            inc[DIV_W-2] = 1'b1;
        end else if (sel == SEL_PLL4X) begin
            inc[DIV_W-3] = 1'b1;
        end else if ((sel == SEL_PLL2X) || (sel[2:0] == 3'b000)) begin
            inc[DIV_W-4] = 1'b1;
        end else if ((sel == SEL_PLL1X) || (sel[3:0] == 4'b1010)) begin
            inc[DIV_W-5] = 1'b1;
        end else if (sel[2:0] == 3'b001) begin
            inc[0] = 1'b1;
        end
    end

endmodule

// File: rtl/tim_sched.sv
// Cog/PLL clock-rate generator: phase accumulator whose rate changes only at a clean wrap.
//
//  state     | meaning
//  ----------+-------------------------------------------------------------
//  ST_RUN    | accumulate at cur_sel rate, watch for a new request
//  ST_DRAIN  | keep old rate until the accumulator wraps, then switch
//  ST_SETTLE | accumulator held at 0 while the settle timer counts down
module tim_sched
    import tim_pkg::*;
#(
    parameter int DIV_W      = 13,
    parameter int SETTLE_CYC = 4
) (
    input  logic       clk,
    input  logic       res,
    input  logic [6:0] cfg,
    output logic       clk_pll,
    output logic       clk_cog,
    output logic       cog_ena,
    output logic       mode_busy,
    output logic [4:0] cur_sel
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);

    logic [6:0]       cfgx_q, cfgx_d;
    logic [4:0]       cur_sel_q, cur_sel_d;
    logic [DIV_W-1:0] acc_q, acc_d;
    logic             msb_q, msb_d;
    tim_state_e       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;

    logic [4:0]       req_sel;
    logic [DIV_W-1:0] inc;
    logic [DIV_W:0]   sum;
    logic             wrap;
    logic             cfg_unused;

    // OSCM bits only matter to the oscillator, not to the rate selection.
    assign cfg_unused = ^cfgx_q[4:3];
    assign req_sel    = {cfgx_q[6:5], cfgx_q[2:0]};

    tim_inc_lut #(.DIV_W(DIV_W)) u_inc_lut (
        .sel (cur_sel_q),
        .inc (inc)
    );

    assign sum  = {1'b0, acc_q} + {1'b0, inc};
    assign wrap = sum[DIV_W];

    always_comb begin
        cfgx_d    = cfg;
        cur_sel_d = cur_sel_q;
        acc_d     = sum[DIV_W-1:0];
        msb_d     = acc_q[DIV_W-1];
        state_d   = state_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            ST_RUN: begin
                if (req_sel != cur_sel_q) begin
                    if (inc == '0) begin
                        // Stopped clock has no edge to wait for.
                        state_d   = ST_SETTLE;
                        cur_sel_d = req_sel;
                        acc_d     = '0;
                        cnt_d     = SETTLE_LOAD;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (wrap) begin
                    state_d   = ST_SETTLE;
                    cur_sel_d = req_sel;
                    acc_d     = '0;
                    cnt_d     = SETTLE_LOAD;
                end
            end
            ST_SETTLE: begin
                acc_d = '0;
                if (cnt_q == 4'd0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // During reset the MSB free-toggles so cogs still see clk_cog edges.
    always_ff @(posedge clk) begin
        msb_q <= msb_d;
        if (res) begin
            cfgx_q    <= '0;
            cur_sel_q <= '0;
            state_q   <= ST_RUN;
            cnt_q     <= '0;
            acc_q     <= {~acc_q[DIV_W-1], {(DIV_W-1){1'b0}}};
        end else begin
            cfgx_q    <= cfgx_d;
            cur_sel_q <= cur_sel_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
        end
    end

    assign clk_cog   = acc_q[DIV_W-1];
    assign cog_ena   = acc_q[DIV_W-1] & ~msb_q;
    assign mode_busy = (state_q != ST_RUN) | (req_sel != cur_sel_q);
    assign cur_sel   = cur_sel_q;
    assign clk_pll   = (cur_sel_q == SEL_PLL16X) ? clk : acc_q[DIV_W-2];

endmodule
